// File: rtl/button_gesture_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_gesture_decoder
// Purpose  : Classifies debounced press/release pulses as short, double or
//            long presses and reports each as a one-cycle registered pulse.
// Revision : 1.0
// ============================================================================
module button_gesture_decoder #(
  parameter int LONG_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_down,
  input  logic btn_up,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic long_active,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PRESSED1  = 3'd1,
    S_LONG_HELD = 3'd2,
    S_WAIT_GAP  = 3'd3,
    S_PRESSED2  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic w_down;
  logic w_up;
  logic w_short;
  logic w_double;
  logic w_long;
  logic w_long_active;
  logic w_busy;

  logic r_short;
  logic r_double;
  logic r_long;
  logic r_long_active;
  logic r_busy;

  always_comb begin
    // A simultaneous press and release carries no usable ordering; drop both.
    w_down        = btn_down & ~btn_up;
    w_up          = btn_up & ~btn_down;
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_short       = 1'b0;
    w_double      = 1'b0;
    w_long        = 1'b0;
    w_long_active = 1'b0;
    w_busy        = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (w_down) begin
          w_state_nxt = S_PRESSED1;
        end
      end
      S_PRESSED1: begin
        if (w_up) begin
          w_state_nxt = S_WAIT_GAP;
        end else if (r_cnt == c_LONG_LAST) begin
          w_state_nxt = S_LONG_HELD;
          w_long      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_LONG_HELD: begin
        if (w_up) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_GAP: begin
        if (w_down) begin
          w_state_nxt = S_PRESSED2;
        end else if (r_cnt == c_GAP_LAST) begin
          w_state_nxt = S_IDLE;
          w_short     = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      S_PRESSED2: begin
        if (w_up) begin
          w_state_nxt = S_IDLE;
          w_double    = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt != r_state) begin
      w_cnt_nxt = '0;
    end

    // Level outputs follow the state being entered so they align with it.
    w_long_active = (w_state_nxt == S_LONG_HELD);
    w_busy        = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_short       <= 1'b0;
      r_double      <= 1'b0;
      r_long        <= 1'b0;
      r_long_active <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_short       <= w_short;
      r_double      <= w_double;
      r_long        <= w_long;
      r_long_active <= w_long_active;
      r_busy        <= w_busy;
    end
  end

  assign short_press  = r_short;
  assign double_press = r_double;
  assign long_press   = r_long;
  assign long_active  = r_long_active;
  assign busy         = r_busy;

endmodule
`default_nettype wire
